// File: rtl/baseline_pkg.sv
// baseline_pkg: shared helper and default sizing for the baseline tracker.
// Holds the ceil-log2 helper used for width derivation, the default
// parameter values and the accumulator widths they imply.
package baseline_pkg;

    // Ceiling log2; returns 0 for n <= 1 so a length-1 window adds no bits.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int DEF_IN_W      = 25;
    localparam int DEF_N0        = 5;
    localparam int DEF_N1        = 6;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_BASE_SEGS = 4;
    localparam int DEF_SHIFT     = 8;

    localparam int BLK_W = DEF_IN_W + clog2(DEF_N0);
    localparam int SEG_W = BLK_W + clog2(DEF_N1);
    localparam int SUM_W = SEG_W + clog2(DEF_BASE_SEGS);

endpackage

// File: rtl/window_accum.sv
// window_accum: counts N accepted inputs and sums them.
// The completed sum and done pulse are combinational on the N-th accept,
// so a following stage can take the sum on that same edge. With N = 1 the
// stage reduces to a sign-extending pass-through.
module window_accum
    import baseline_pkg::*;
#(
    parameter int IN_W  = 25,
    parameter int ACC_W = 28,
    parameter int N     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_accept,
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_done
);

    localparam int CNT_W = (N > 1) ? clog2(N) : 1;

    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_ext;
    logic                    w_last;

    assign w_ext  = ACC_W'(i_data);
    assign w_last = (r_cnt == CNT_W'(N - 1));
    assign o_sum  = r_acc + w_ext;
    assign o_done = i_accept && w_last;

    // Advance the window on each accept; the last accept reloads to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_accept) begin
            if (w_last) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= o_sum;
            end
        end
    end

endmodule

// File: rtl/baseline_tracker.sv
// baseline_tracker: decimates a signed feature stream into block sums and
// segment sums, keeps the last DEPTH segment sums in a ring, and once the
// ring is full emits the sum of the oldest BASE_SEGS segments, arithmetically
// shifted right by SHIFT, one cycle after each completed segment.
// Optional build macro: BASELINE_FREEZE_EN adds i_freeze, which discards
// completing segments so the baseline stops adapting during events.
module baseline_tracker
    import baseline_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int N0        = DEF_N0,
    parameter int N1        = DEF_N1,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BASE_SEGS = DEF_BASE_SEGS,
    parameter int SHIFT     = DEF_SHIFT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic signed [IN_W-1:0] i_din,
    input  logic                   i_din_valid,
`ifdef BASELINE_FREEZE_EN
    input  logic                   i_freeze,
`endif
    output logic signed [IN_W+clog2(N0)+clog2(N1)+clog2(BASE_SEGS)-1:0] o_dout,
    output logic                   o_dout_valid,
    output logic                   o_hist_full
);

    localparam int STG0_W = IN_W + clog2(N0);
    localparam int STG1_W = STG0_W + clog2(N1);
    localparam int OUT_W  = STG1_W + clog2(BASE_SEGS);
    localparam int PTR_W  = clog2(DEPTH);
    localparam int FILL_W = clog2(DEPTH + 1);

    logic                     w_accept;
    logic signed [STG0_W-1:0] w_blk_sum;
    logic                     w_blk_done;
    logic signed [STG1_W-1:0] w_seg_sum;
    logic                     w_seg_done;
    logic                     w_write;
    logic [PTR_W-1:0]         w_ptr_next;
    logic [FILL_W-1:0]        w_fill_next;
    logic signed [OUT_W-1:0]  w_base_sum;

    logic signed [STG1_W-1:0] r_ring [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [FILL_W-1:0]        r_fill;
    logic                     r_full;
    logic                     r_pend;
    logic signed [OUT_W-1:0]  r_dout;
    logic                     r_dout_valid;

    assign w_accept = i_en && i_din_valid;

    window_accum #(
        .IN_W  (IN_W),
        .ACC_W (STG0_W),
        .N     (N0)
    ) u_stage0 (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_accept),
        .i_data   (i_din),
        .o_sum    (w_blk_sum),
        .o_done   (w_blk_done)
    );

    window_accum #(
        .IN_W  (STG0_W),
        .ACC_W (STG1_W),
        .N     (N1)
    ) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_blk_done),
        .i_data   (w_blk_sum),
        .o_sum    (w_seg_sum),
        .o_done   (w_seg_done)
    );

`ifdef BASELINE_FREEZE_EN
    assign w_write = w_seg_done && !i_freeze;
`else
    assign w_write = w_seg_done;
`endif

    assign w_ptr_next  = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_fill_next = (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + FILL_W'(1);

    // Store each completed segment sum at the write pointer.
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_ring[r_wr_ptr] <= w_seg_sum;
        end
    end

    // Pointer, fill level and the request for an output update next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_full   <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_pend <= w_write;
            if (w_write) begin
                r_wr_ptr <= w_ptr_next;
                r_fill   <= w_fill_next;
                r_full   <= (w_fill_next == FILL_W'(DEPTH));
            end
        end
    end

    // Oldest BASE_SEGS entries start at the write pointer and run forward.
    always_comb begin
        w_base_sum = '0;
        for (int i = 0; i < BASE_SEGS; i++) begin
            w_base_sum = w_base_sum
                       + OUT_W'(r_ring[PTR_W'((int'(r_wr_ptr) + i) % DEPTH)]);
        end
    end

    // Publish the shifted baseline one cycle after a write into a full ring.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= r_pend && r_full;
            if (r_pend && r_full) begin
                r_dout <= w_base_sum >>> SHIFT;
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_hist_full  = r_full;

endmodule

// File: tb/tb_baseline_tracker.sv
// tb_baseline_tracker: directed bench for baseline_tracker at default
// parameters. A reference model computes segment sums and pushes each
// expected baseline, tagged with the step it must appear on, into a queue
// that is popped when the output should pulse.
// Build with BASELINE_FREEZE_EN to include the freeze scenario.
module tb_baseline_tracker;

    localparam int IN_W      = 25;
    localparam int N0        = 5;
    localparam int N1        = 6;
    localparam int DEPTH     = 8;
    localparam int BASE_SEGS = 4;
    localparam int SHIFT     = 8;
    localparam int OUT_W     = 33;

    typedef struct {
        longint value;
        int     step;
    } expItem_t;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic signed [IN_W-1:0]  din;
    logic                    dinValid;
    logic signed [OUT_W-1:0] dout;
    logic                    doutValid;
    logic                    histFull;
`ifdef BASELINE_FREEZE_EN
    logic                    freeze;
`endif

    int       total;
    int       bad;
    int       stepIdx;
    int       acceptCount;
    int       firstPulseAt;
    int       cnt0;
    int       cnt1;
    longint   acc0;
    longint   acc1;
    longint   lastDout;
    longint   segHist[$];
    expItem_t expQ[$];

    baseline_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .i_din        (din),
        .i_din_valid  (dinValid),
`ifdef BASELINE_FREEZE_EN
        .i_freeze     (freeze),
`endif
        .o_dout       (dout),
        .o_dout_valid (doutValid),
        .o_hist_full  (histFull)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        cnt0 = 0;
        cnt1 = 0;
        acc0 = 0;
        acc1 = 0;
        segHist.delete();
        expQ.delete();
        acceptCount  = 0;
        lastDout     = 0;
        firstPulseAt = -1;
    endtask

    task automatic modelAccept(input int d, input bit fz);
        longint   seg;
        longint   sum;
        expItem_t item;
        acceptCount++;
        acc0 += longint'(d);
        cnt0++;
        if (cnt0 == N0) begin
            acc1 += acc0;
            acc0 = 0;
            cnt0 = 0;
            cnt1++;
            if (cnt1 == N1) begin
                seg  = acc1;
                acc1 = 0;
                cnt1 = 0;
                if (!fz) begin
                    segHist.push_back(seg);
                    if (segHist.size() > DEPTH) void'(segHist.pop_front());
                    if (segHist.size() == DEPTH) begin
                        sum = 0;
                        for (int i = 0; i < BASE_SEGS; i++) sum += segHist[i];
                        item.value = sum >>> SHIFT;
                        item.step  = stepIdx + 1;
                        expQ.push_back(item);
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input int acceptsBefore);
        expItem_t item;
        checkValue("hist_full", longint'(histFull), (segHist.size() == DEPTH) ? 1 : 0);
        if (expQ.size() > 0 && expQ[0].step == stepIdx) begin
            item = expQ.pop_front();
            checkValue("pulse_valid", longint'(doutValid), 1);
            checkValue("pulse_dout", longint'(dout), item.value);
            lastDout = item.value;
        end else begin
            checkValue("idle_valid", longint'(doutValid), 0);
            checkValue("hold_dout", longint'(dout), lastDout);
        end
        if (doutValid === 1'b1 && firstPulseAt < 0) firstPulseAt = acceptsBefore;
    endtask

    task automatic applyStimulus(input int d, input bit v, input bit e, input bit r, input bit fz);
        int acceptsBefore;
        din      = IN_W'(d);
        dinValid = v;
        en       = e;
        rst      = r;
`ifdef BASELINE_FREEZE_EN
        freeze   = fz;
`endif
        acceptsBefore = acceptCount;
        @(posedge clk);
        stepIdx++;
        if (r) modelReset();
        else if (v && e) modelAccept(d, fz);
        @(negedge clk);
        checkOutput(acceptsBefore);
    endtask

    task automatic runSegments(input int firstK, input int lastK);
        for (int k = firstK; k <= lastK; k++) begin
            for (int s = 0; s < N0 * N1; s++) applyStimulus(k * 256, 1, 1, 0, 0);
        end
        applyStimulus(0, 0, 1, 0, 0);
    endtask

    // Directed scenario sequence.
    initial begin
        bit dropA;
        bit dropB;
        total   = 0;
        bad     = 0;
        stepIdx = 0;
        modelReset();
        rst      = 1'b1;
        en       = 1'b0;
        dinValid = 1'b0;
        din      = '0;
`ifdef BASELINE_FREEZE_EN
        freeze   = 1'b0;
`endif

        repeat (2) applyStimulus(0, 0, 0, 1, 0);
        checkValue("reset_dout", longint'(dout), 0);
        checkValue("reset_valid", longint'(doutValid), 0);
        checkValue("reset_full", longint'(histFull), 0);

        $display("[TB] constant +256");
        for (int i = 0; i < 300; i++) applyStimulus(256, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkValue("first_pulse_accepts", firstPulseAt, 240);
        checkValue("const_pos_dout", longint'(dout), 120);

        $display("[TB] constant -256 then -1");
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 240; i++) applyStimulus(-256, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkValue("const_neg_dout", longint'(dout), -120);
        for (int i = 0; i < 240; i++) applyStimulus(-1, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkValue("floor_dout", longint'(dout), -1);

        $display("[TB] segment ramp");
        applyStimulus(0, 0, 0, 1, 0);
        runSegments(1, 8);
        checkValue("ramp8_dout", longint'(dout), 300);
        runSegments(9, 9);
        checkValue("ramp9_dout", longint'(dout), 420);

        $display("[TB] gapped valid and enable drops");
        applyStimulus(0, 0, 0, 1, 0);
        dropA = 1'b0;
        dropB = 1'b0;
        for (int s = 0; s < 3000 && acceptCount < 300; s++) begin
            if (acceptCount == 62 && !dropA) begin
                repeat (10) applyStimulus(256, 1, 0, 0, 0);
                dropA = 1'b1;
            end else if (acceptCount == 270 && !dropB) begin
                repeat (3) applyStimulus(256, 1, 0, 0, 0);
                dropB = 1'b1;
            end else begin
                applyStimulus(256, 1'($urandom_range(0, 1)), 1, 0, 0);
            end
        end
        applyStimulus(0, 0, 1, 0, 0);
        checkValue("gapped_accepts", acceptCount, 300);
        checkValue("gapped_first_pulse", firstPulseAt, 240);
        checkValue("gapped_dout", longint'(dout), 120);

        $display("[TB] mid-operation reset");
        for (int i = 0; i < 100; i++) applyStimulus(256, 1, 1, 0, 0);
        applyStimulus(256, 1, 1, 1, 0);
        checkValue("midrst_dout", longint'(dout), 0);
        checkValue("midrst_full", longint'(histFull), 0);
        for (int i = 0; i < 240; i++) applyStimulus(256, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkValue("midrst_first_pulse", firstPulseAt, 240);
        checkValue("midrst_dout_after", longint'(dout), 120);

`ifdef BASELINE_FREEZE_EN
        $display("[TB] freeze on segment 9");
        applyStimulus(0, 0, 0, 1, 0);
        runSegments(1, 8);
        checkValue("frz_ramp8_dout", longint'(dout), 300);
        for (int s = 0; s < N0 * N1 - 1; s++) applyStimulus(9 * 256, 1, 1, 0, 0);
        applyStimulus(9 * 256, 1, 1, 0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkValue("frz_hold_dout", longint'(dout), 300);
        checkValue("frz_full", longint'(histFull), 1);
        runSegments(10, 10);
        checkValue("frz_seg10_dout", longint'(dout), 420);
`endif

        checkValue("leftover_expected", longint'(expQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baseline_tracker.md
Name: baseline_tracker

Overview:
- Parametrised successor to the fixed 5/6/8 baseline block in the seizure-feature datapath.
- Decimates a feature stream into non-overlapping block sums, then into segment sums, and keeps a ring of the last DEPTH segment sums.
- Emits a scaled baseline equal to the sum of the oldest BASE_SEGS segments, once per completed segment, with a one-cycle valid pulse to the controller.

Parameters:
- IN_W, 25, signed input sample width
- N0, 5, samples per block (>=1)
- N1, 6, blocks per segment (>=1)
- DEPTH, 8, segment history depth (>=2)
- BASE_SEGS, 4, oldest segments summed into the baseline (1..DEPTH)
- SHIFT, 8, arithmetic right shift applied to the baseline sum
- OUT_W, IN_W+clog2(N0)+clog2(N1)+clog2(BASE_SEGS), output width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  active-high enable; when low, samples are ignored and all state holds
- din  in  IN_W  signed sample
- din_valid  in  1  sample strobe; sample accepted on an edge where din_valid && en
- dout  out  OUT_W  signed baseline, (sum of oldest BASE_SEGS segments) >>> SHIFT
- dout_valid  out  1  one-cycle pulse; dout updated
- hist_full  out  1  high once DEPTH segments are held
- freeze  in  1  present only with BASELINE_FREEZE_EN

Behaviour:
- Reset (rst high at an edge):
  - Clear the sample counter, block counter, both accumulators, the fill counter and the ring write pointer.
  - dout=0, dout_valid=0, hist_full=0.
  - Ring contents are don't-care.
  - Reset overrides a simultaneous accept.
  - A mid-operation reset discards every partial sum.
- Stage 0 (block accumulation):
  - Sign-extend din to IN_W+clog2(N0) bits and accumulate.
  - On the N0-th accepted sample, the block sum is acc0+din, acc0 reloads to 0 and cnt0 wraps to 0.
  - The block sum is handed to stage 1 on the same edge, with no extra cycle.
- Stage 1 (segment accumulation):
  - Identical structure with N1, producing the segment sum at SEG_W=IN_W+clog2(N0)+clog2(N1).
- N0=1 or N1=1 degenerates to a pass-through of that stage, with no added latency.
- Segment write:
  - On the edge where a segment completes (edge E), the segment sum is written at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - fill increments, saturating at DEPTH.
  - hist_full = (fill == DEPTH), registered.
- Baseline:
  - After edge E, the oldest BASE_SEGS entries are the entries at wr_ptr, wr_ptr+1, ... wr_ptr+BASE_SEGS-1 (mod DEPTH), and are valid only when full.
  - Sum them in OUT_W bits with no overflow possible, then apply arithmetic shift right by SHIFT, which floors toward minus infinity.
- Output timing:
  - dout and dout_valid are registered at edge E+1.
  - dout_valid is high for exactly one cycle, and only if fill == DEPTH after E.
  - dout holds its value between pulses.
- Throughput: the first dout_valid needs N0*N1*DEPTH accepted samples; after that there is one pulse per N0*N1 accepted samples.
- en low or din_valid low: counters, accumulators and the ring hold. A pending E+1 output update still completes.
- Back-to-back segment completions (N0=N1=1): a segment on every accepted cycle gives a pulse every cycle; the pipeline must sustain this.

Optional Feature:
- BASELINE_FREEZE_EN defined:
  - Adds the freeze input.
  - While freeze is high, a completing segment is discarded: no ring write, no pointer/fill change, no dout_valid. dout holds.
  - Stage 0/1 counters still run, so segment alignment is preserved.
  - Used to stop the baseline adapting during detected events.
- Undefined: no freeze port; every completed segment is written.

Decomposition:
- Package baseline_pkg:
  - clog2 function
  - default constants (N0/N1/DEPTH/BASE_SEGS/SHIFT)
  - derived width localparams (BLK_W, SEG_W, SUM_W)
- One natural sub-module, window_accum:
  - Parameters: width, count N.
  - Function: counter plus accumulator with accept-in, sum-out and done pulse.
  - Instantiated twice, for stages 0 and 1.
- Ring, pointer and baseline summer live in baseline_tracker.

Test Plan:
- Defaults, din=256 constant, din_valid=1 → first dout_valid after exactly 240 accepts; dout=(4*7680)>>>8=120; subsequent pulses every 30 accepts, value 120.
- din=-256 constant → dout=-120; with din=-1 constant, dout=(-4*30)>>>8=-1 (floor check).
- Segment k (k=1..9) drives all samples = k*256 → after segment 8: dout=300; after segment 9: dout=420 (window slides correctly across the wrap).
- din_valid toggled randomly and en dropped for 10 cycles mid-block, using the constant-256 stimulus → identical dout sequence to the continuous run; no pulses while en=0.
- rst asserted for 1 cycle after 100 accepts → dout=0, hist_full=0; the next dout_valid comes only after another 240 accepts.
- BASELINE_FREEZE_EN, segment-ramp stimulus with freeze high during segment 9's completing edge → no pulse and dout stays 300; segment 10 then yields the oldest 4 of segments 1..8,10, i.e. segments 2..5, so dout=420.
